mips_bus_mem_if: RTL and testbench
==================================

// Module: mips_bus_mem_if
// PURPOSE
//  Memory-access stage between the multicycle datapath's load/store requests and the Avalon-style
//  bus (address/read/write/waitrequest/byteenable). Accepts one byte/half/word request, holds
//  read/write until waitrequest drops, generates byteenable, replicates store lanes, and
//  aligns/extends load data. Stalls the decoder FSM while a transfer is outstanding.
// PARAMETERS
//  ADDR_W   32   byte-address width; bus address is {req_addr[ADDR_W-1:2],2'b00}
// PORTS
//  clk          in   1       single clock; all state on posedge
//  reset        in   1       asynchronous, active-high
//  req_valid    in   1       level; CPU holds request until rsp_valid
//  req_write    in   1       1=store, 0=load
//  req_size     in   2       mips_bus_pkg::size_t: BYTE=00, HALF=01, WORD=10 (11 treated as WORD)
//  req_signed   in   1       load sign-extend (byte/half only)
//  req_addr     in   ADDR_W  byte address
//  req_wdata    in   32      store data, right-justified
//  cpu_stall    out  1       transfer pending
//  rsp_valid    out  1       one-cycle completion pulse
//  rsp_rdata    out  32      aligned/extended load data (0 for stores)
//  rsp_err      out  1       misaligned-access flag (see CONFIGURATION)
//  address      out  32      bus word address
//  read         out  1       bus read strobe
//  write        out  1       bus write strobe
//  waitrequest  in   1       bus stall
//  writedata    out  32      bus store data, lane-replicated
//  byteenable   out  4       bus lane enables
//  readdata     in   32      bus load data, valid in cycle waitrequest=0
// BEHAVIOUR
//  - Reset (async): state IDLE; read, write, rsp_valid, rsp_err=0; address, writedata, rsp_rdata=0;
//    byteenable=0. Reset mid-transfer drops read/write immediately; no response is issued.
//  - FSM IDLE -> BUS -> IDLE. Accept in IDLE when req_valid & !rsp_valid: latch request;
//    next cycle state=BUS with read=!req_write, write=req_write, address/byteenable/writedata registered.
//  - BUS: strobes and bus outputs held constant while waitrequest=1 (no timeout). On waitrequest=0:
//    capture readdata, drop strobes, go IDLE, assert rsp_valid the following cycle.
//  - Latency: accept cycle N, strobe N+1, rsp_valid N+2 with zero wait; +1 per waitrequest cycle.
//  - cpu_stall = (state==BUS) | (state==IDLE & req_valid & !rsp_valid); low in rsp_valid cycle.
//  - A request held high in the rsp_valid cycle is not re-accepted (prevents double issue).
//  - Little-endian lanes: BYTE be=4'b0001<<a[1:0]; HALF be=a[1]?1100:0011; WORD be=1111.
//  - Store data: BYTE {4{wd[7:0]}}; HALF {2{wd[15:0]}}; WORD wd.
//  - Load: select lane by a[1:0]/a[1]; zero- or sign-extend per req_signed; WORD passes through.
// CONFIGURATION
//  MIPS_BUS_ALIGN_CHECK_EN defined: HALF with a[0]=1 or WORD with a[1:0]!=0 never strobes the
//   bus; goes to response next cycle with rsp_valid=1, rsp_err=1, rsp_rdata=0.
//  Undefined: rsp_err tied 0; WORD ignores a[1:0], HALF ignores a[0].
// STRUCTURE
//  mips_bus_pkg: size_t enum, state_t enum {IDLE,BUS}, BE_* lane constants.
//  Sub-module mips_bus_lane_align (combinational): byteenable, writedata replicate, load extract/extend.
// TESTING
//  1 LW 0x100, wait=0, readdata=0xDEADBEEF -> read@N+1, be=1111, rsp_valid@N+2, rdata=0xDEADBEEF.
//  2 LB signed 0x103, readdata=0x80FF0011 -> be=1000, rdata=0xFFFFFF80; unsigned -> 0x00000080.
//  3 SH 0x102 wd=0x0000ABCD, waitrequest=1 for 3 cycles -> write held 4 cycles, be=1100,
//    writedata=0xABCDABCD, address=0x100, stall high throughout, one rsp_valid.
//  4 reset asserted in BUS with waitrequest=1 -> read=0 same cycle, no rsp_valid after release.
//  5 back-to-back LW with req_valid held -> second accepted only in cycle after rsp_valid.
//  6 (ALIGN_CHECK_EN) LW 0x102 -> read never asserted, rsp_valid+rsp_err next cycle, rdata=0.

Source files
------------

// File: rtl/mips_bus_pkg.sv
// Shared types and lane constants for the MIPS memory-stage bus interface.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_t;

  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/mips_bus_lane_align.sv
// Little-endian lane logic: byte enables, store replication and load extract/extend.
// Size code 2'b11 falls through to word behaviour; half accesses look only at addr_lo[1].
module mips_bus_lane_align
  import mips_bus_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  byteenable,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (addr_lo)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    byteenable = BE_WORD;
    wdata_rep  = wdata;
    rdata_ext  = rdata;
    if (size == SZ_BYTE) begin
      byteenable = BE_BYTE0 << addr_lo;
      wdata_rep  = {4{wdata[7:0]}};
      rdata_ext  = {{24{sign_ext & lane_b[7]}}, lane_b};
    end else if (size == SZ_HALF) begin
      byteenable = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
      wdata_rep  = {2{wdata[15:0]}};
      rdata_ext  = {{16{sign_ext & lane_h[15]}}, lane_h};
    end
  end

endmodule

// File: rtl/mips_bus_mem_if.sv
// Memory-access stage: one load/store per request onto an Avalon-style bus, stalling the CPU meanwhile.
// Define MIPS_BUS_ALIGN_CHECK_EN to reject misaligned half/word accesses with rsp_err instead of issuing them.
module mips_bus_mem_if
  import mips_bus_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              cpu_stall,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [31:0]       address,
  output logic              read,
  output logic              write,
  input  logic              waitrequest,
  output logic [31:0]       writedata,
  output logic [3:0]        byteenable,
  input  logic [31:0]       readdata
);

  state_t      state;
  logic [1:0]  size_q;
  logic [1:0]  addr_lo_q;
  logic        signed_q;
  logic        write_q;
  logic        accept;
  logic        misaligned;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] rdata_c;

  // rsp_valid blocks acceptance so a request still held during the response is not issued twice
  assign accept    = (state == IDLE) & req_valid & !rsp_valid;
  assign cpu_stall = (state == BUS) | accept;

`ifdef MIPS_BUS_ALIGN_CHECK_EN
  assign misaligned = ((req_size == SZ_HALF) & req_addr[0]) |
                      (req_size[1] & (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
  assign rsp_err    = 1'b0;
`endif

  // One lane aligner serves both directions: request fields in IDLE, latched fields during BUS
  mips_bus_lane_align u_align (
    .size       ((state == BUS) ? size_q    : req_size),
    .addr_lo    ((state == BUS) ? addr_lo_q : req_addr[1:0]),
    .sign_ext   ((state == BUS) ? signed_q  : req_signed),
    .wdata      (req_wdata),
    .rdata      (readdata),
    .byteenable (be_c),
    .wdata_rep  (wdata_c),
    .rdata_ext  (rdata_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      read       <= 1'b0;
      write      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      address    <= '0;
      writedata  <= '0;
      byteenable <= '0;
      size_q     <= SZ_BYTE;
      addr_lo_q  <= 2'b00;
      signed_q   <= 1'b0;
      write_q    <= 1'b0;
`ifdef MIPS_BUS_ALIGN_CHECK_EN
      rsp_err    <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
`ifdef MIPS_BUS_ALIGN_CHECK_EN
      rsp_err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept && misaligned) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
`ifdef MIPS_BUS_ALIGN_CHECK_EN
            rsp_err   <= 1'b1;
`endif
          end else if (accept) begin
            state      <= BUS;
            read       <= !req_write;
            write      <= req_write;
            address    <= 32'({req_addr[ADDR_W-1:2], 2'b00});
            byteenable <= be_c;
            writedata  <= wdata_c;
            size_q     <= req_size;
            addr_lo_q  <= req_addr[1:0];
            signed_q   <= req_signed;
            write_q    <= req_write;
          end
        end
        BUS: begin
          if (!waitrequest) begin
            state     <= IDLE;
            read      <= 1'b0;
            write     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= write_q ? 32'd0 : rdata_c;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_bus_mem_if.sv
// Scoreboard bench for mips_bus_mem_if: expected responses queued at request time, popped on rsp_valid.
module tb_mips_bus_mem_if;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        cpu_stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  int n_checks = 0;
  int n_errors = 0;
  logic [32:0] sb[$];
  logic [32:0] sb_head;

  always #5 clk = ~clk;

  mips_bus_mem_if #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .cpu_stall(cpu_stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .address(address), .read(read), .write(write), .waitrequest(waitrequest),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] load_model(input logic [1:0] sz, input logic sg,
                                             input logic [1:0] a, input logic [31:0] rd);
    logic [31:0] sh;
    if (sz == 2'b00) begin
      sh = rd >> (int'(a) * 8);
      return sg ? {{24{sh[7]}}, sh[7:0]} : {24'd0, sh[7:0]};
    end else if (sz == 2'b01) begin
      sh = rd >> (int'(a[1]) * 16);
      return sg ? {{16{sh[15]}}, sh[15:0]} : {16'd0, sh[15:0]};
    end
    return rd;
  endfunction

  function automatic logic [3:0] be_model(input logic [1:0] sz, input logic [1:0] a);
    if (sz == 2'b00) return 4'b0001 << a;
    if (sz == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  // Response monitor: every rsp_valid must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        check_eq("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        sb_head = sb.pop_front();
        check_eq("rsp_rdata", rsp_rdata, sb_head[31:0]);
        check_eq("rsp_err", 32'(rsp_err), 32'(sb_head[32]));
      end
    end
  end

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int nwait, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_rd, input logic b2b, input logic keep);
    if (!b2b) @(negedge clk);
    req_valid   = 1'b1;
    req_write   = w;
    req_size    = sz;
    req_signed  = sg;
    req_addr    = a;
    req_wdata   = wd;
    readdata    = rd;
    waitrequest = (nwait > 0);
    sb.push_back({1'b0, w ? 32'd0 : exp_rd});
    #1;
    check_eq("stall_accept", 32'(cpu_stall), 32'(!b2b));
    if (b2b) begin
      @(negedge clk);
      check_eq("no_reissue", 32'({read, write}), 32'd0);
      check_eq("stall_wait", 32'(cpu_stall), 32'd1);
    end
    @(negedge clk);
    check_eq("strobe", 32'({read, write}), 32'({!w, w}));
    check_eq("address", address, {a[31:2], 2'b00});
    check_eq("byteenable", 32'(byteenable), 32'(exp_be));
    if (w) check_eq("writedata", writedata, exp_wd);
    check_eq("stall_bus", 32'(cpu_stall), 32'd1);
    for (int i = 1; i <= nwait; i++) begin
      @(negedge clk);
      check_eq("strobe_held", 32'({read, write}), 32'({!w, w}));
      check_eq("addr_held", address, {a[31:2], 2'b00});
      check_eq("stall_held", 32'(cpu_stall), 32'd1);
      if (i == nwait) waitrequest = 1'b0;
    end
    @(negedge clk);
    check_eq("strobe_drop", 32'({read, write}), 32'd0);
    check_eq("rsp_pulse", 32'(rsp_valid), 32'd1);
    check_eq("stall_rsp", 32'(cpu_stall), 32'd0);
    readdata = $urandom;
    if (!keep) req_valid = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_size    = 2'b10;
    req_signed  = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    waitrequest = 1'b0;
    readdata    = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_strobes", 32'({read, write}), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_be", 32'(byteenable), 32'd0);
    check_eq("rst_address", address, 32'd0);
    check_eq("rst_rdata", rsp_rdata, 32'd0);
    check_eq("rst_stall", 32'(cpu_stall), 32'd0);
    reset = 1'b0;

    // word load, zero wait
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
    // byte loads on the top lane, signed and unsigned
    do_req(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FF0011, 0, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b0, 1'b0);
    do_req(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FF0011, 1, 4'b1000, 32'h0, 32'h00000080, 1'b0, 1'b0);
    // half store with three wait cycles
    do_req(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000ABCD, 32'h0, 3, 4'b1100, 32'hABCDABCD, 32'h0, 1'b0, 1'b0);
    // byte store, word store with size code 11
    do_req(1'b1, 2'b00, 1'b0, 32'h101, 32'h12345678, 32'h0, 0, 4'b0010, 32'h78787878, 32'h0, 1'b0, 1'b0);
    do_req(1'b1, 2'b11, 1'b0, 32'h204, 32'hCAFEF00D, 32'h0, 2, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
    // back-to-back loads with req_valid held across the response
    do_req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'h11223344, 0, 4'b1111, 32'h0, 32'h11223344, 1'b0, 1'b1);
    do_req(1'b0, 2'b10, 1'b0, 32'h204, 32'h0, 32'h55667788, 1, 4'b1111, 32'h0, 32'h55667788, 1'b1, 1'b0);

    // all byte/half offsets with random bus data
    for (int a = 0; a < 4; a++) begin
      for (int s = 0; s < 2; s++) begin
        for (int g = 0; g < 2; g++) begin
          logic [31:0] rd;
          rd = $urandom;
          do_req(1'b0, 2'(s), 1'(g), 32'h400 + 32'(a), 32'h0, rd, a % 2, be_model(2'(s), 2'(a)),
                 32'h0, load_model(2'(s), 1'(g), 2'(a), rd), 1'b0, 1'b0);
        end
      end
    end

`ifdef MIPS_BUS_ALIGN_CHECK_EN
    // misaligned word: no bus cycle, error response next cycle
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h102;
    readdata = 32'h12345678; waitrequest = 1'b0;
    sb.push_back({1'b1, 32'd0});
    @(negedge clk);
    check_eq("mis_no_read", 32'(read), 32'd0);
    check_eq("mis_rsp", 32'(rsp_valid), 32'd1);
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("mis_no_read2", 32'(read), 32'd0);
`else
    // without alignment checking, low address bits are ignored for a word
    do_req(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h12345678, 0, 4'b1111, 32'h0, 32'h12345678, 1'b0, 1'b0);
    do_req(1'b0, 2'b01, 1'b0, 32'h103, 32'h0, 32'hA1B2C3D4, 0, 4'b1100, 32'h0, 32'h0000A1B2, 1'b0, 1'b0);
`endif

    // reset in the middle of a stalled transfer
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h300;
    waitrequest = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_read_pre", 32'(read), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("rst_mid_read", 32'(read), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    waitrequest = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("rst_mid_idle", 32'({read, write, rsp_valid}), 32'd0);

    @(negedge clk);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
